// File: rtl/sum5_rr_sequencer.sv
// rtl/sum5_rr_sequencer.sv - round-robin shared serial five-operand adder
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req        per-requester request, bit i = requester i
//   opnd_in    flattened operands, requester i operand k at [(i*5+k)*WIDTH +: WIDTH]
//   grant      registered one-hot grant, held from capture through DONE
//   busy       high whenever a job is in flight
//   out_valid  one-cycle result pulse
//   out_id     requester index of the result
//   out_sum    A+B+C+D+E modulo 2^WIDTH
//   out_ovf    carry-out seen in any of the four additions
module sum5_rr_sequencer #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*5*WIDTH-1:0] opnd_in,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    out_valid,
  output logic [IDW-1:0]          out_id,
  output logic [WIDTH-1:0]        out_sum,
  output logic                    out_ovf
);

  typedef enum logic [2:0] {IDLE, ADD1, ADD2, ADD3, ADD4, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur_id;
  logic [WIDTH-1:0] acc;
  logic             ovf_acc;
  // Operands B..E; op_r[0] always feeds the adder, shifted down each ADD step.
  logic [WIDTH-1:0] op_r [4];
  logic [WIDTH-1:0] opnd [NREQ][5];
  logic [IDW-1:0]   win;
  logic             win_found;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH:0]   add_res;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 5; k++) begin
        opnd[i][k] = opnd_in[(i*5+k)*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin scan: first set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[IDW'(idx)]) begin
        win_found = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
  assign add_res = {1'b0, acc} + {1'b0, op_r[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = ADD1;
      ADD1:    state_nxt = ADD2;
      ADD2:    state_nxt = ADD3;
      ADD3:    state_nxt = ADD4;
      ADD4:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      cur_id    <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      for (int k = 0; k < 4; k++) op_r[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            acc     <= opnd[win][0];
            for (int k = 0; k < 4; k++) op_r[k] <= opnd[win][k+1];
            ovf_acc <= 1'b0;
            grant   <= NREQ'(1) << win;
            ptr     <= ptr_nxt;
            cur_id  <= win;
          end
        end
        ADD1, ADD2, ADD3, ADD4: begin
          acc     <= add_res[WIDTH-1:0];
          ovf_acc <= ovf_acc | add_res[WIDTH];
          for (int k = 0; k < 3; k++) op_r[k] <= op_r[k+1];
          if (state == ADD4) begin
            out_sum   <= add_res[WIDTH-1:0];
            out_ovf   <= ovf_acc | add_res[WIDTH];
            out_id    <= cur_id;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          grant     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum5_rr_sequencer.sv
// tb/tb_sum5_rr_sequencer.sv - directed self-checking bench for sum5_rr_sequencer
module tb_sum5_rr_sequencer;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*5*WIDTH-1:0] opnd_in;
  logic [NREQ-1:0]         grant;
  logic                    busy;
  logic                    out_valid;
  logic [IDW-1:0]          out_id;
  logic [WIDTH-1:0]        out_sum;
  logic                    out_ovf;

  int npass = 0;
  int nchk  = 0;

  sum5_rr_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .opnd_in(opnd_in),
    .grant(grant), .busy(busy), .out_valid(out_valid),
    .out_id(out_id), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
    opnd_in[(i*5+0)*WIDTH +: WIDTH] = a;
    opnd_in[(i*5+1)*WIDTH +: WIDTH] = b;
    opnd_in[(i*5+2)*WIDTH +: WIDTH] = c;
    opnd_in[(i*5+3)*WIDTH +: WIDTH] = d;
    opnd_in[(i*5+4)*WIDTH +: WIDTH] = e;
  endtask

  // Called right after the capture edge; walks ADD1..DONE and back to IDLE.
  // mid_req/mid_opnd are applied while the job is in ADD2.
  task automatic finish_job(input int id, input logic [31:0] sum, input logic ovf,
                            input logic [NREQ-1:0] mid_req,
                            input logic [NREQ*5*WIDTH-1:0] mid_opnd);
    logic [NREQ-1:0] g;
    g = 4'b0001 << id;
    chk("cap_grant", grant, g);
    chk("cap_busy", busy, 1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        req     = mid_req;
        opnd_in = mid_opnd;
      end
      chk("run_grant", grant, g);
      chk("run_valid", out_valid, 0);
    end
    tick();
    chk("done_valid", out_valid, 1);
    chk("done_sum", out_sum, sum);
    chk("done_id", out_id, id);
    chk("done_ovf", out_ovf, ovf);
    chk("done_grant", grant, g);
    chk("done_busy", busy, 1);
    tick();
    chk("post_valid", out_valid, 0);
    chk("post_grant", grant, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    opnd_in = '0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_ovf, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Single job, requester 0: 1+2+3+4+5
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 32'(i*16+1), 32'(i*16+2), 32'(i*16+3), 32'(i*16+4), 32'(i*16+5));
    req = 4'b0001;
    tick();
    req = 4'b0000;
    finish_job(0, 32'd15, 1'b0, req, opnd_in);

    // All requesting continuously from a fresh pointer: order 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 4) req = 4'b0000;
      finish_job(j % 4, 32'(80*(j % 4) + 15), 1'b0, req, opnd_in);
    end

    // Wrap to zero with carry, then large sum without carry (pointer now 1)
    set_ops(1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    finish_job(1, 32'h0, 1'b1, req, opnd_in);
    set_ops(1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    finish_job(1, 32'h8000_0000, 1'b0, req, opnd_in);

    // Requester 2 operands change in ADD2; requester 0 raises req mid-job
    set_ops(2, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    begin
      logic [NREQ*5*WIDTH-1:0] alt;
      alt = opnd_in;
      for (int k = 0; k < 5; k++) alt[(2*5+k)*WIDTH +: WIDTH] = 32'd1000;
      finish_job(2, 32'd150, 1'b0, 4'b0001, alt);
    end
    tick();
    req = 4'b0000;
    finish_job(0, 32'd15, 1'b0, req, opnd_in);

    // Reset during ADD3 (pointer now 1, so requester 3 wins)
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_id", out_id, 0);
    chk("abort_sum", out_sum, 0);
    chk("abort_ovf", out_ovf, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
    end
    set_ops(1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    req = 4'b1010;
    tick();
    req = 4'b0000;
    finish_job(1, 32'd5, 1'b0, req, opnd_in);

    // Requester 3: five times 0x80000000, then hold check (pointer now 2)
    set_ops(3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    finish_job(3, 32'h8000_0000, 1'b1, req, opnd_in);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_sum", out_sum, 32'h8000_0000);
      chk("hold_id", out_id, 3);
      chk("hold_ovf", out_ovf, 1);
      chk("hold_valid", out_valid, 0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
